// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clock, reset_n, start, op, rs, rt, mf_req, mthi, mtlo, mt_data -> busy, done, stall, hi, lo.
module muldiv_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        mf_req,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] d_reg;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div0;

    logic        op_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod;
    logic [63:0] prod_neg;

    assign op_signed = ~op[0];
    assign rs_neg    = op_signed & rs[31];
    assign rt_neg    = op_signed & rt[31];
    assign abs_rs    = rs_neg ? (~rs + 32'd1) : rs;
    assign abs_rt    = rt_neg ? (~rt + 32'd1) : rt;

    // multiply: d_reg = multiplicand, p_lo shifts the multiplier out
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, d_reg} : 33'd0);

    // divide: p_hi = partial remainder, p_lo shifts dividend out / quotient in
    assign div_sh   = {p_hi, p_lo[31]};
    assign div_ge   = (div_sh >= {1'b0, d_reg});
    // when div_ge, the true difference is below d_reg, so 32 bits suffice
    assign div_diff = div_sh[31:0] - d_reg;

    assign prod     = {p_hi, p_lo};
    assign prod_neg = ~prod + 64'd1;

    assign stall = busy & (start | mf_req | mthi | mtlo);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            d_reg   <= 32'd0;
            p_hi    <= 32'd0;
            p_lo    <= 32'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    d_reg   <= op[1] ? abs_rt : abs_rs;
                    p_lo    <= op[1] ? abs_rs : abs_rt;
                    p_hi    <= 32'd0;
                    is_div  <= op[1];
                    neg_res <= rs_neg ^ rt_neg;
                    neg_rem <= rs_neg;
                    div0    <= op[1] & (rt == 32'd0);
                    cnt     <= 5'd0;
                    busy    <= 1'b1;
                    state   <= S_CALC;
                end else begin
                    if (mthi) hi <= mt_data;
                    if (mtlo) lo <= mt_data;
                end
            end else if (state == S_CALC) begin
                if (is_div) begin
                    p_hi <= div_ge ? div_diff : div_sh[31:0];
                    p_lo <= {p_lo[30:0], div_ge};
                end else begin
                    {p_hi, p_lo} <= {mul_sum, p_lo[31:1]};
                end
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) state <= S_FIX;
            end else if (state == S_FIX) begin
                if (is_div) begin
                    // divide by zero: quotient all ones, remainder restores to rs
                    lo <= div0 ? 32'hFFFF_FFFF
                               : (neg_res ? (~p_lo + 32'd1) : p_lo);
                    hi <= neg_rem ? (~p_hi + 32'd1) : p_hi;
                end else begin
                    {hi, lo} <= neg_res ? prod_neg : prod;
                end
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
            end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: results, latency, mt writes,
// stall/ignore while busy and asynchronous reset abort.
module tb_muldiv_ctrl;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mf_req;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    muldiv_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .mf_req  (mf_req),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op on the next negedge; returns edges from accept to done
    // and the number of cycles busy was seen high. Also checks that done
    // cleared at the accept edge and hi/lo hold mid-operation.
    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt);
        logic [31:0] h0;
        logic [31:0] l0;
        @(negedge clock);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        h0    = hi;
        l0    = lo;
        @(posedge clock);
        #1;
        start    = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        chk({nm, " done_clr"}, {63'd0, done}, 64'd0);
        while (!done && edges < 50) begin
            if (busy) busy_cnt++;
            if (edges == 16) chk({nm, " hold"}, {hi, lo}, {h0, l0});
            @(posedge clock);
            #1;
            edges++;
        end
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: done never seen", nm);
        end
    endtask

    int edges;
    int bcnt;

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        rs       = 32'd0;
        rt       = 32'd0;
        mf_req   = 1'b0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        mt_data  = 32'd0;

        vecs[0] = '{"mult_neg2x3", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{"divu_by0",    2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF};
        vecs[5] = '{"div_neg_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{"mult_min2",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7] = '{"div_7_m2",    2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{"divu_big",    2'b11, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9] = '{"mult_7_m1",   2'b00, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};

        #12;
        chk("reset_state", {59'd0, busy, done, stall, (hi != 0), (lo != 0)}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // back-to-back table: each op is issued in the cycle done is high
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, edges, bcnt);
            chk({vecs[i].name, " latency"}, 64'(edges), 64'd33);
            chk({vecs[i].name, " busy_cycles"}, 64'(bcnt), 64'd33);
            chk({vecs[i].name, " hilo"}, {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        @(posedge clock);
        #1;
        chk("done_pulse", {63'd0, done}, 64'd0);

        // mt writes in idle; mf_req while idle gives no stall
        @(negedge clock);
        mthi = 1'b1; mt_data = 32'h0000AAAA; mf_req = 1'b1;
        #1;
        chk("idle_no_stall", {63'd0, stall}, 64'd0);
        @(posedge clock); #1;
        mthi = 1'b0; mf_req = 1'b0;
        @(negedge clock);
        mtlo = 1'b1; mt_data = 32'h0000BBBB;
        @(posedge clock); #1;
        mtlo = 1'b0;
        chk("mt_write", {hi, lo}, {32'h0000AAAA, 32'h0000BBBB});

        // start with mthi in the same cycle: start wins
        @(negedge clock);
        start = 1'b1; op = 2'b11; rs = 32'd10; rt = 32'd3;
        mthi = 1'b1; mt_data = 32'h55;
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0;
        chk("start_wins", {hi, lo}, {32'h0000AAAA, 32'h0000BBBB});
        edges = 0;
        repeat (4) begin
            @(posedge clock); #1; edges++;
        end
        @(negedge clock);
        start = 1'b1; op = 2'b00; rs = 32'd7; rt = 32'd9;
        mf_req = 1'b1; mthi = 1'b1; mt_data = 32'h55;
        #1;
        chk("busy_stall", {63'd0, stall}, 64'd1);
        @(posedge clock); #1;
        edges++;
        start = 1'b0; mf_req = 1'b0; mthi = 1'b0;
        chk("ignored_mthi", {hi, lo}, {32'h0000AAAA, 32'h0000BBBB});
        while (!done && edges < 50) begin
            @(posedge clock); #1; edges++;
        end
        chk("ignore_latency", 64'(edges), 64'd33);
        chk("ignore_result", {hi, lo}, {32'd1, 32'd3});
        @(posedge clock); #1;
        chk("ignore_no_restart", {63'd0, busy}, 64'd0);

        // asynchronous reset in the middle of a MULT
        @(negedge clock);
        start = 1'b1; op = 2'b00; rs = 32'd1000; rt = 32'd1000;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {59'd0, busy, done, stall, (hi != 0), (lo != 0)}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("post_reset", 2'b00, 32'd6, 32'hFFFFFFF9, edges, bcnt);
        chk("post_reset latency", 64'(edges), 64'd33);
        chk("post_reset hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFD6});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  issue request for a multiply or divide.
REQ-005 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 rs  input  32  multiplicand or dividend.
REQ-007 rt  input  32  multiplier or divisor.
REQ-008 mf_req  input  1  MFHI/MFLO read request from the pipeline.
REQ-009 mthi, mtlo  input  1 each  direct write request to HI or LO.
REQ-010 mt_data  input  32  write data for mthi and mtlo.
REQ-011 busy  output  1  an operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 stall  output  1  pipeline hold request.
REQ-014 hi, lo  output  32 each  architectural HI and LO registers.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and FIX; IDLE is the reset state.
REQ-016 Accept: when start=1 in IDLE, the rising edge SHALL latch |rs| and |rt| (raw values for 01/11), the op, the result-sign flags and the dividend sign, clear the 5-bit iteration counter, set busy=1 and go to CALC.
REQ-017 CALC SHALL perform exactly one iteration per edge: a shift-add step for multiply or a restoring subtract-shift step for divide.
REQ-018 The counter SHALL increment on every CALC edge; the edge at which counter=31 SHALL go to FIX.
REQ-019 The FIX edge SHALL apply sign correction, write hi/lo, set done=1, clear busy and return to IDLE; done SHALL clear on the next edge.
REQ-020 Latency: hi, lo and done SHALL update on the 33rd edge after the accept edge; busy SHALL be high for exactly 33 cycles.
REQ-021 Multiply SHALL place the 64-bit product in {hi,lo}; signed ops SHALL two's-complement the product when exactly one operand is negative.
REQ-022 Divide SHALL put the quotient in lo and the remainder in hi.
REQ-023 Signed divide SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-024 Divide by zero (rt=0, either divide op) SHALL give hi=rs and lo=0xFFFFFFFF with normal latency.
REQ-025 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give lo=0x80000000 and hi=0.
REQ-026 stall SHALL be a combinational output equal to busy & (start | mf_req | mthi | mtlo).
REQ-027 While busy, start, mthi and mtlo SHALL be ignored (no state change).
REQ-028 In IDLE, mthi/mtlo SHALL write mt_data into hi/lo on the edge; if start is also high, start SHALL win and the mt write SHALL be dropped.
REQ-029 hi and lo SHALL hold their previous values throughout CALC and change only at FIX or on an mt write.
REQ-030 A start in the same cycle that done=1 SHALL be accepted normally (back-to-back issue).

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clear all internal operand registers.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no hi/lo update.
REQ-033 Deassertion of reset SHALL take effect synchronously; the first start SHALL be accepted on the first edge after reset_n=1.

Verification
REQ-034 MULT with rs=0xFFFFFFFE and rt=3 -> hi=0xFFFFFFFF and lo=0xFFFFFFFA; done pulses exactly 33 edges after accept; busy is high 33 cycles.
REQ-035 MULTU with rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE and lo=0x00000001.
REQ-036 DIV with rs=0xFFFFFFF9 (-7) and rt=2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIV with 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 and hi=0.
REQ-037 DIVU with rs=100 and rt=0 -> hi=0x00000064 and lo=0xFFFFFFFF.
REQ-038 Issue DIVU 10/3, then at cycle 5 drive start=1 (op=00), mf_req=1 and mthi=1 with mt_data=0x55 -> stall=1 in those cycles, second op ignored, and final hi=1, lo=3.
REQ-039 Drive reset_n=0 at cycle 10 of a MULT -> busy, done, hi and lo read 0 before the next edge; a new start after release completes correctly.
